// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Word offset within a line: pc[off_w+1:2].
  function automatic logic [31:0] get_off(input logic [31:0] pc, input int unsigned off_w);
    logic [31:0] mask;
    mask = (32'd1 << off_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  // Line index: pc[off_w+idx_w+1:off_w+2].
  function automatic logic [31:0] get_idx(input logic [31:0] pc, input int unsigned off_w,
                                          input int unsigned idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> (off_w + 2)) & mask;
  endfunction

  // Tag: everything above the index field.
  function automatic logic [31:0] get_tag(input logic [31:0] pc, input int unsigned off_w,
                                          input int unsigned idx_w);
    return pc >> (off_w + idx_w + 2);
  endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays for the instruction cache: asynchronous read, one refill write port.
module icache_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned OFF_W = $clog2(WORDS),
  parameter int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             line_set,
  input  logic [TAG_W-1:0] line_tag,
  input  logic             flush
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[{rd_idx, rd_off}];

  // Flush wins over line_set so a pending invalidate also drops the line just filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (line_set) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_set) begin
      tag_q[wr_idx] <= line_tag;
    end
    if (wr_en) begin
      data_q[{wr_idx, wr_off}] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a line-refill FSM toward word-wide memory.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  icache_state_t    state_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;
  logic [OFF_W-1:0] cnt_q;
  logic             inv_pend_q;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;

  logic hit;
  logic fill_ack;
  logic fill_last;
  logic flush;

  assign tag = TAG_W'(get_tag(pc, OFF_W, IDX_W));
  assign idx = IDX_W'(get_idx(pc, OFF_W, IDX_W));
  assign off = OFF_W'(get_off(pc, OFF_W));

  // Reset is folded in so the reset cycle itself never reports a hit or a request.
  assign hit       = !reset && (state_q == IDLE) && rd_valid && (rd_tag == tag);
  assign mem_req   = !reset && (state_q == REFILL);
  assign fill_ack  = mem_req && mem_ack;
  assign fill_last = fill_ack && (cnt_q == LAST_WORD);

  assign stall    = !hit;
  assign instr    = hit ? rd_data : NOP_INSTR;
  assign mem_addr = mem_req ? {miss_tag_q, miss_idx_q, cnt_q, 2'b00} : 32'h0;

  // Invalidate acts immediately in IDLE; during a refill it is deferred to the final word.
  assign flush = !reset && (((state_q == IDLE) && invalidate) ||
                            (fill_last && (inv_pend_q || invalidate)));

  icache_store #(
    .LINES(LINES),
    .WORDS(WORDS),
    .IDX_W(IDX_W),
    .OFF_W(OFF_W),
    .TAG_W(TAG_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_off   (off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_ack),
    .wr_idx   (miss_idx_q),
    .wr_off   (cnt_q),
    .wr_data  (mem_rdata),
    .line_set (fill_last),
    .line_tag (miss_tag_q),
    .flush    (flush)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          inv_pend_q <= 1'b0;
          if (!hit) begin
            state_q    <= REFILL;
            miss_tag_q <= tag;
            miss_idx_q <= idx;
            cnt_q      <= '0;
          end
        end
        REFILL: begin
          if (invalidate) begin
            inv_pend_q <= 1'b1;
          end
          if (mem_ack) begin
            cnt_q <= cnt_q + OFF_W'(1);
            if (cnt_q == LAST_WORD) begin
              state_q    <= IDLE;
              inv_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: a line-level reference model fed by a synthetic memory.
module tb_icache_dm;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  icache_dm #(
    .LINES(16),
    .WORDS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .stall      (stall),
    .invalidate (invalidate),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] seed;

  // Reference model: which line address each index holds, plus an in-flight refill.
  bit [15:0]   m_valid;
  logic [27:0] m_line [16];
  bit          m_busy;
  logic [27:0] m_base;
  int          m_words;
  bit          m_pend;

  logic        obs_stall, exp_stall, obs_req, exp_req;
  logic [31:0] obs_instr, exp_instr, obs_addr, exp_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic string got_want();
    return $sformatf("got stall=%b instr=%h req=%b addr=%h, want stall=%b instr=%h req=%b addr=%h",
                     obs_stall, obs_instr, obs_req, obs_addr,
                     exp_stall, exp_instr, exp_req, exp_addr);
  endfunction

  // Drive one cycle, sample outputs mid-cycle, compute model expectations, advance the model.
  task automatic step(input logic [31:0] p, input bit inv, input bit ack, input bit rst);
    logic [27:0] la;
    int ix;
    bit h;
    @(negedge clk);
    pc = p; invalidate = inv; mem_ack = ack; reset = rst;
    #1;
    la = p[31:4];
    ix = int'(la[3:0]);
    h = !rst && !m_busy && m_valid[ix] && (m_line[ix] == la);
    exp_stall = !h;
    exp_instr = h ? memf(p) : 32'h0;
    exp_req   = !rst && m_busy;
    exp_addr  = exp_req ? ({m_base, 4'b0000} + 32'(4 * m_words)) : 32'h0;
    obs_stall = stall; obs_instr = instr; obs_req = mem_req; obs_addr = mem_addr;
    mem_rdata = exp_req ? memf(exp_addr) : $urandom;
    if (rst) begin
      m_busy = 0; m_valid = '0; m_pend = 0;
    end else if (!m_busy) begin
      if (inv) m_valid = '0;
      if (!h) begin
        m_busy = 1; m_base = la; m_words = 0;
      end
    end else begin
      if (inv) m_pend = 1;
      if (ack) begin
        m_words++;
        if (m_words == 4) begin
          m_line[int'(m_base[3:0])] = m_base;
          m_valid[int'(m_base[3:0])] = 1'b1;
          if (m_pend) m_valid = '0;
          m_pend = 0;
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(32'h0000_0040, 1'b0, 1'b1, 1'b1);
      if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
          obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL reset cycle %0d: %s", k, got_want());
      end
      n_checks++;
    end
    step(32'h0000_0040, 1'b0, 1'b0, 1'b0);
    if (obs_stall !== 1'b1 || obs_instr !== 32'h0 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL first_after_reset: %s", got_want());
    end
    n_checks++;
  endtask

  task automatic test_cold_miss();
    int n_st = 0;
    bit done = 0;
    step(32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && !done; k++) begin
      step(32'h0000_0040, 1'b0, 1'b1, 1'b0);
      if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
          obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL cold_miss cycle %0d: %s", k, got_want());
      end
      n_checks++;
      if (obs_stall) n_st++;
      if (!exp_stall) done = 1;
    end
    if (n_st != 5 || !done) begin
      n_fail++; $display("FAIL cold_miss_latency: got %0d stall cycles, want 5", n_st);
    end
    n_checks++;
    step(32'h0000_004C, 1'b0, 1'b0, 1'b0);
    if (obs_stall !== 1'b0 || obs_instr !== memf(32'h4C)) begin
      n_fail++; $display("FAIL cold_hit_last_word: %s", got_want());
    end
    n_checks++;
  endtask

  task automatic test_slow_memory();
    int first_free = 0;
    bit a;
    step(32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 14 && first_free == 0; k++) begin
      a = (k == 2 || k == 5 || k == 6 || k == 9);
      step(32'h0000_0040, 1'b0, a, 1'b0);
      if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
          obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL slow_memory cycle %0d: %s", k, got_want());
      end
      n_checks++;
      if (!obs_stall) first_free = k;
    end
    if (first_free != 10) begin
      n_fail++; $display("FAIL slow_memory_release: got first hit cycle %0d, want 10", first_free);
    end
    n_checks++;
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0000};
    step(32'h0, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      bit done = 0;
      for (int k = 0; k < 30 && !done; k++) begin
        step(seq[s], 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
            obs_addr !== exp_addr) begin
          n_fail++; $display("FAIL conflict access %0d cycle %0d: %s", s, k, got_want());
        end
        n_checks++;
        if (k == 0 && obs_stall !== 1'b1) begin
          n_fail++; $display("FAIL conflict_miss %0d: got stall=%b, want 1", s, obs_stall);
        end
        if (k == 0) n_checks++;
        if (k == 1 && obs_addr !== seq[s]) begin
          n_fail++; $display("FAIL conflict_addr %0d: got %h, want %h", s, obs_addr, seq[s]);
        end
        if (k == 1) n_checks++;
        if (!exp_stall) done = 1;
      end
      if (!done) begin
        n_fail++; $display("FAIL conflict_timeout %0d: refill never completed", s);
      end
    end
  endtask

  task automatic test_invalidate_mid_refill();
    bit done = 0;
    step(32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 30 && !done; k++) begin
      bit inv = m_busy && m_words == 1;
      step(32'h0000_0300, inv, 1'b1, 1'b0);
      if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
          obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL invalidate_refill cycle %0d: %s", k, got_want());
      end
      n_checks++;
      if (!m_busy && k > 0) done = 1;
    end
    step(32'h0000_0300, 1'b0, 1'b0, 1'b0);
    if (obs_stall !== 1'b1 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL invalidate_reaccess: %s", got_want());
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_refill();
    int acks = 0;
    bit done = 0;
    step(32'h0, 1'b0, 1'b0, 1'b1);
    step(32'h0000_0200, 1'b0, 1'b0, 1'b0);
    step(32'h0000_0200, 1'b0, 1'b1, 1'b0);
    step(32'h0000_0200, 1'b0, 1'b1, 1'b0);
    step(32'h0000_0200, 1'b0, 1'b0, 1'b1);
    if (obs_req !== 1'b0 || obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_refill: %s", got_want());
    end
    n_checks++;
    for (int k = 0; k < 30 && !done; k++) begin
      step(32'h0000_0200, 1'b0, 1'b1, 1'b0);
      if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
          obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL reset_refill cycle %0d: %s", k, got_want());
      end
      n_checks++;
      if (obs_req) acks++;
      if (!exp_stall) done = 1;
    end
    if (acks != 4) begin
      n_fail++; $display("FAIL reset_refill_words: got %0d words, want 4", acks);
    end
    n_checks++;
  endtask

  task automatic test_stray_ack_pc_change();
    int starts = 0;
    bit prev_req = 0;
    bit done = 0;
    step(32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40 && !done; k++) begin
      step((k < 2) ? 32'h0000_0040 : 32'h0000_0080, 1'b0, 1'b1, 1'b0);
      if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
          obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL pc_change cycle %0d: %s", k, got_want());
      end
      n_checks++;
      if (obs_req && !prev_req) starts++;
      prev_req = obs_req;
      if (!exp_stall) done = 1;
    end
    if (starts != 2) begin
      n_fail++; $display("FAIL pc_change_refills: got %0d refills, want 2", starts);
    end
    n_checks++;
    for (int k = 0; k < 3; k++) begin
      step(32'h0000_0040 + 32'(4 * k), 1'b0, 1'b1, 1'b0);
      if (obs_stall !== 1'b0 || obs_instr !== exp_instr || obs_req !== 1'b0) begin
        n_fail++; $display("FAIL stray_ack_hit %0d: %s", k, got_want());
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] p;
      p = ($urandom & 32'h0000_03FC) | (32'($urandom_range(0, 2)) << 12);
      step(p, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 199) == 0));
      if (obs_stall !== exp_stall || obs_instr !== exp_instr || obs_req !== exp_req ||
          obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL random cycle %0d pc=%h: %s", k, p, got_want());
      end
      n_checks++;
    end
  endtask

  initial begin
    seed = $urandom;
    reset = 1'b1; pc = '0; invalidate = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    m_valid = '0; m_busy = 0; m_base = '0; m_words = 0; m_pend = 0;
    for (int i = 0; i < 16; i++) m_line[i] = '0;
    test_reset();
    test_cold_miss();
    test_slow_memory();
    test_conflict();
    test_invalidate_mid_refill();
    test_reset_mid_refill();
    test_stray_ack_pc_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
